// File: rtl/misr_pkg.sv
// Shared types and the signature update step for the multi-channel MISR.
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_t;

    localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEF = 16'h0000;
    localparam int          MISR_MAX_W    = 64;

    // Operates at the widest supported width; callers cast back to their own.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] fb;
        mask = (w >= 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
        fb   = sig[6'(w - 32'd1)] ? poly : '0;
        return ((sig << 1) ^ fb ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_channel.sv
// One MISR channel: IDLE/RUN/DONE control, sample counter, signature register.
// Golden comparator and pass register exist only with MISR_GOLDEN_CMP_EN.
module misr_channel
    import misr_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY     = MISR_POLY_DEF,
    parameter logic [SIG_W-1:0] SEED     = MISR_SEED_DEF,
    parameter int              FRAME_LEN = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              rdy_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SIG_W-1:0]  golden_i,
    output logic [SIG_W-1:0]  sig_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    misr_state_t      r_state;
    misr_state_t      w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nx;
    logic             w_acc;
    logic             w_last;

    assign w_acc  = en_i & rdy_i & (r_state != DONE);
    assign w_last = (r_cnt == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sig   <= SEED;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sig   <= w_sig_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sig_nx   = r_sig;
        // Clear wins over a coincident strobe; that sample is dropped.
        if (clear_i) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_sig_nx   = SEED;
        end else begin
            case (r_state)
                IDLE, RUN: begin
                    if (en_i) w_state_nx = RUN;
                    if (w_acc) begin
                        w_sig_nx = SIG_W'(misr_step(64'(r_sig), 64'(data_i),
                                                    64'(POLY), SIG_W));
                        w_cnt_nx = r_cnt + CNT_W'(1);
                        if (w_last) w_state_nx = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sig_o  = r_sig;
    assign busy_o = (r_state == RUN);
    assign done_o = (r_state == DONE);

`ifdef MISR_GOLDEN_CMP_EN
    logic r_pass;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_pass <= 1'b0;
        end else begin
            r_pass <= (r_state == DONE) && (r_sig == golden_i);
        end
    end

    assign pass_o = r_pass;
`else
    logic w_golden_unused;
    assign w_golden_unused = ^golden_i;
    assign pass_o          = 1'b0;
`endif

endmodule

// File: rtl/multi_misr_monitor.sv
// NUM_CH independent MISR channels plus signature readout mux.
// Define MISR_GOLDEN_CMP_EN to build the golden comparators behind pass_o.
module multi_misr_monitor
    import misr_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               NUM_CH    = 2,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY      = MISR_POLY_DEF,
    parameter logic [SIG_W-1:0] SEED      = MISR_SEED_DEF,
    parameter int               FRAME_LEN = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NUM_CH-1:0]        clear_i,
    input  logic [NUM_CH-1:0]        rdy_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH*SIG_W-1:0]  golden_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel_i,
    output logic [SIG_W-1:0]         sig_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic [NUM_CH-1:0]        done_o,
    output logic [NUM_CH-1:0]        pass_o
);

    logic [SIG_W-1:0] w_sig_ch [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        misr_channel #(
            .DATA_W    (DATA_W),
            .SIG_W     (SIG_W),
            .POLY      (POLY),
            .SEED      (SEED),
            .FRAME_LEN (FRAME_LEN)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (en_i),
            .clear_i  (clear_i[c]),
            .rdy_i    (rdy_i[c]),
            .data_i   (data_i[c*DATA_W +: DATA_W]),
            .golden_i (golden_i[c*SIG_W +: SIG_W]),
            .sig_o    (w_sig_ch[c]),
            .busy_o   (busy_o[c]),
            .done_o   (done_o[c]),
            .pass_o   (pass_o[c])
        );
    end

    // Selects with no matching channel read back as zero.
    always_comb begin
        sig_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(rd_sel_i) == 32'(c)) sig_o = w_sig_ch[c];
        end
    end

endmodule

// File: tb/tb_multi_misr_monitor.sv
// Randomised and directed bench for multi_misr_monitor against a
// polynomial-arithmetic reference model.
module tb_multi_misr_monitor;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int SW = 16;
    localparam int FL = 4;
`ifdef MISR_GOLDEN_CMP_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en;
    logic [NC-1:0]    clr, rdy;
    logic [NC*DW-1:0] data;
    logic [NC*SW-1:0] gold;
    logic [0:0]       rsel;
    logic [SW-1:0]    sig;
    logic [NC-1:0]    busy, done, pass;

    logic             b_en;
    logic [NC-1:0]    b_rdy, b_clr;
    logic [NC*DW-1:0] b_data;
    logic [NC*SW-1:0] b_gold;
    logic [0:0]       b_rsel;
    logic [SW-1:0]    b_sig;
    logic [NC-1:0]    b_busy, b_done, b_pass;

    multi_misr_monitor #(
        .DATA_W(DW), .NUM_CH(NC), .SIG_W(SW),
        .POLY(16'h1021), .SEED(16'h0000), .FRAME_LEN(FL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr),
        .rdy_i(rdy), .data_i(data), .golden_i(gold), .rd_sel_i(rsel),
        .sig_o(sig), .busy_o(busy), .done_o(done), .pass_o(pass)
    );

    multi_misr_monitor #(
        .DATA_W(DW), .NUM_CH(NC), .SIG_W(SW),
        .POLY(16'h1021), .SEED(16'h8000), .FRAME_LEN(FL)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(b_en), .clear_i(b_clr),
        .rdy_i(b_rdy), .data_i(b_data), .golden_i(b_gold),
        .rd_sel_i(b_rsel), .sig_o(b_sig), .busy_o(b_busy),
        .done_o(b_done), .pass_o(b_pass)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: 0 = idle, 1 = running, 2 = frame complete.
    int          m_st  [NC];
    int          m_cnt [NC];
    logic [15:0] m_sig [NC];
    logic        m_pass[NC];

    // sig * x + data, reduced modulo x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] ref_step(input logic [15:0] s,
                                             input logic [7:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0] ^ {8'h00, d};
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NC; c++) begin
            bit acc;
            acc = en && rdy[c] && (m_st[c] != 2);
            if (rst) begin
                m_st[c] = 0; m_cnt[c] = 0; m_sig[c] = 16'h0000; m_pass[c] = 1'b0;
            end else if (clr[c]) begin
                m_st[c] = 0; m_cnt[c] = 0; m_sig[c] = 16'h0000; m_pass[c] = 1'b0;
            end else begin
                m_pass[c] = (m_st[c] == 2) && (m_sig[c] == gold[c*SW +: SW]);
                if (m_st[c] != 2 && en) m_st[c] = 1;
                if (acc) begin
                    m_sig[c] = ref_step(m_sig[c], data[c*DW +: DW]);
                    m_cnt[c]++;
                    if (m_cnt[c] == FL) m_st[c] = 2;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("busy%0d", c), busy[c], m_st[c] == 1);
            chk($sformatf("done%0d", c), done[c], m_st[c] == 2);
            chk($sformatf("pass%0d", c), pass[c], GOLD & m_pass[c]);
        end
        chk("sig_o", sig, m_sig[rsel]);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = '0; rdy = '0; data = '0; gold = '0;
        rsel = '0;
        b_en = 1'b0; b_rdy = '0; b_clr = '0; b_data = '0; b_gold = '0;
        b_rsel = '0;
        for (int c = 0; c < NC; c++) begin
            m_st[c] = 0; m_cnt[c] = 0; m_sig[c] = '0; m_pass[c] = 1'b0;
        end
        cyc(); cyc();
        chk("rst_sig", sig, 16'h0000);
        chk("rst_b_sig", b_sig, 16'h8000);
        rst = 1'b0;

        // Plain shift with no feedback
        en = 1'b1; rdy = 2'b01; data[7:0] = 8'h01;
        cyc(); chk("t1_s1", sig, 16'h0001);
        data[7:0] = 8'h00;
        cyc(); chk("t1_s2", sig, 16'h0002);
        cyc(); chk("t1_s3", sig, 16'h0004);
        cyc(); chk("t1_s4", sig, 16'h0008);
        chk("t1_done", done[0], 1'b1);
        chk("t1_busy", busy[0], 1'b0);

        // Golden compare, one cycle after done
        rdy = '0; gold[15:0] = 16'h0008;
        cyc(); chk("t3_pass", pass[0], GOLD);
        gold[15:0] = 16'h0009;
        cyc(); chk("t3_nopass", pass[0], 1'b0);

        // Feedback from seed 0x8000
        b_en = 1'b1; b_rdy = 2'b01; b_data[7:0] = 8'h80;
        cyc(); chk("t2_fb", b_sig, 16'h10a1);
        b_en = 1'b0; b_rdy = '0;

        // Pause then clear
        clr = 2'b11;
        cyc(); chk("t4_clr", sig, 16'h0000);
        clr = '0; en = 1'b1; rdy = 2'b01; data[7:0] = 8'h01;
        cyc();
        data[7:0] = 8'h00;
        cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdy[0] = ~rdy[0];
            data = NC*DW'($urandom);
            cyc(); chk("t4_hold", sig, 16'h0002);
        end
        en = 1'b1; clr[0] = 1'b1; rdy[0] = 1'b1; data[7:0] = 8'h55;
        cyc(); chk("t4_clr_rdy", sig, 16'h0000);
        chk("t4_idle", busy[0] | done[0], 1'b0);
        clr = '0;

        // Random independent traffic
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            rdy  = NC'($urandom);
            data = NC*DW'($urandom);
            rsel = 1'($urandom);
            for (int c = 0; c < NC; c++) begin
                clr[c] = ($urandom_range(0, 29) == 0);
                gold[c*SW +: SW] = $urandom_range(0, 1) ? m_sig[c]
                                                        : SW'($urandom);
            end
            cyc();
        end
        clr = '0; rdy = '0;
        rsel = 1'b1; #1;
        chk("t5_rsel1", sig, m_sig[1]);
        rsel = 1'b0; #1;
        chk("t5_rsel0", sig, m_sig[0]);

        // Reset mid-frame, then a fresh frame
        clr = 2'b11; cyc(); clr = '0;
        en = 1'b1; rdy = 2'b11;
        for (int i = 0; i < 3; i++) begin
            data = NC*DW'($urandom);
            cyc();
        end
        rst = 1'b1;
        cyc(); chk("t6_sig", sig, 16'h0000);
        chk("t6_busy", busy, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < FL; i++) begin
            data = NC*DW'($urandom);
            cyc();
        end
        chk("t6_done", done, 2'b11);
        rdy = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
